// File: rtl/gpio_dir_ctrl.sv
// APB slave owning GPIO direction and output state. It sequences the one-cycle
// w1/r1 pulses that flip the per-pin RS direction flops and synchronises pad inputs.
module gpio_dir_ctrl #(
    parameter int NPINS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [3:0]       paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] dir,
    output logic [NPINS-1:0] w1,
    output logic [NPINS-1:0] r1
);
    typedef enum logic [1:0] {IDLE, ACCESS, PULSE, RESP} state_t;

    localparam logic [1:0] REG_DIR = 2'd0;
    localparam logic [1:0] REG_OUT = 2'd1;
    localparam logic [1:0] REG_IN  = 2'd2;
    localparam logic [1:0] REG_RSV = 2'd3;

    state_t           state_q, state_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic [1:0]       reg_q, reg_d;
    logic [NPINS-1:0] wdata_q, wdata_d;
    logic [NPINS-1:0] dir_q, dir_d;
    logic [NPINS-1:0] out_q, out_d;
    logic [NPINS-1:0] sync1_q, sync2_q;
    logic [NPINS-1:0] w1_q, w1_d;
    logic [NPINS-1:0] r1_q, r1_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;

    logic setup_err, setup_slow, slow_q;

    // Only the low NPINS bits of pwdata are meaningful.
    logic unused_pwdata;
    assign unused_pwdata = ^pwdata;

    assign setup_err  = (paddr[1:0] != 2'b00) || (paddr[3:2] == REG_RSV) ||
                        (pwrite && paddr[3:2] == REG_IN);
    assign setup_slow = !setup_err && (pwrite ? paddr[3:2] == REG_DIR : paddr[3:2] == REG_IN);
    assign slow_q     = !err_q && (wr_q ? reg_q == REG_DIR : reg_q == REG_IN);

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        err_d     = err_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        dir_d     = dir_q;
        out_d     = out_q;
        w1_d      = '0;
        r1_d      = '0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d   = ACCESS;
                    wr_d      = pwrite;
                    err_d     = setup_err;
                    reg_d     = paddr[3:2];
                    wdata_d   = pwdata[NPINS-1:0];
                    // Fast transfers complete in the access cycle, so their response is staged now.
                    pready_d  = !setup_slow;
                    pslverr_d = setup_err;
                    if (!setup_err && !pwrite) begin
                        if (paddr[3:2] == REG_DIR)      prdata_d = 32'(dir_q);
                        else if (paddr[3:2] == REG_OUT) prdata_d = 32'(out_q);
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (psel && !err_q) begin
                    if (wr_q && reg_q == REG_OUT) begin
                        out_d = wdata_q;
                    end else if (slow_q) begin
                        state_d = PULSE;
                        if (wr_q) begin
                            w1_d = wdata_q & ~dir_q;
                            r1_d = ~wdata_q & dir_q;
                        end
                    end
                end
            end
            PULSE: begin
                // The pulse is already on the pins, so dir must follow even on abort.
                if (wr_q) dir_d = wdata_q;
                else      prdata_d = 32'(sync2_q);
                if (psel) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                    prdata_d = '0;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            reg_q     <= 2'd0;
            wdata_q   <= '0;
            dir_q     <= '0;
            out_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            w1_q      <= '0;
            r1_q      <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
            w1_q      <= w1_d;
            r1_q      <= r1_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign gpio_out = out_q;
    assign dir      = dir_q;
    assign w1       = w1_q;
    assign r1       = r1_q;
endmodule

// File: tb/tb_gpio_dir_ctrl.sv
// Bench for gpio_dir_ctrl: directed and random APB transfers against a register-level model.
module tb_gpio_dir_ctrl;
    localparam int NP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psel, penable, pwrite;
    logic [3:0]    paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr;
    logic [NP-1:0] gpio_in, gpio_out, dir, w1, r1;

    int checks = 0;
    int errors = 0;

    logic [NP-1:0] m_dir, m_out, m_in;

    always #5 clk = ~clk;

    gpio_dir_ctrl #(.NPINS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .dir(dir), .w1(w1), .r1(r1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One full APB transfer; next_in is applied to the pads once it completes.
    task automatic xfer(input logic [3:0] a, input logic wr, input logic [31:0] d,
                        input logic [NP-1:0] next_in);
        int            waits, exp_waits;
        logic          done, got_err, exp_err;
        logic [31:0]   got_rd, exp_rd;
        logic [NP-1:0] got_w1, got_r1, exp_w1, exp_r1;

        exp_err   = (a[1:0] != 2'b00) || (a[3:2] == 2'd3) || (wr && a[3:2] == 2'd2);
        exp_waits = (!exp_err && ((wr && a[3:2] == 2'd0) || (!wr && a[3:2] == 2'd2))) ? 2 : 0;
        exp_w1 = '0; exp_r1 = '0; exp_rd = '0;
        if (!exp_err) begin
            if (wr && a[3:2] == 2'd0)
                for (int i = 0; i < NP; i++) begin
                    if (d[i] && !m_dir[i]) exp_w1[i] = 1'b1;   // input -> output
                    if (!d[i] && m_dir[i]) exp_r1[i] = 1'b1;   // output -> input
                end
            if (!wr)
                case (a[3:2])
                    2'd0: exp_rd = 32'(m_dir);
                    2'd1: exp_rd = 32'(m_out);
                    default: exp_rd = 32'(m_in);
                endcase
        end

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; done = 1'b0; got_w1 = '0; got_r1 = '0; got_rd = '0; got_err = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (c == 1 && exp_waits == 2) begin
                got_w1 = w1; got_r1 = r1;
            end else begin
                chk("stray_pulse", 32'({w1, r1}), 32'd0);
            end
            if (pready) begin
                done = 1'b1; got_rd = prdata; got_err = pslverr;
            end else begin
                chk("pslverr_without_pready", 32'(pslverr), 32'd0);
                waits++;
                @(posedge clk); #1;
            end
        end
        chk("pready_timeout", 32'(done), 32'd1);
        chk("latency", 32'(waits), 32'(exp_waits));
        chk("w1", 32'(got_w1), 32'(exp_w1));
        chk("r1", 32'(got_r1), 32'(exp_r1));
        chk("prdata", got_rd, exp_rd);
        chk("pslverr", 32'(got_err), 32'(exp_err));

        if (!exp_err && wr) begin
            if (a[3:2] == 2'd0) m_dir = d[NP-1:0];
            if (a[3:2] == 2'd1) m_out = d[NP-1:0];
        end

        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        gpio_in = next_in;
        m_in = next_in;
        @(negedge clk);
        chk("pready_one_cycle", 32'(pready), 32'd0);
        chk("dir", 32'(dir), 32'(m_dir));
        chk("gpio_out", 32'(gpio_out), 32'(m_out));
    endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rd;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        m_dir = '0; m_out = '0; m_in = '0;

        #12;
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_w1r1", 32'({w1, r1}), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_gpio_out", 32'(gpio_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pulses", 32'({w1, r1}), 32'd0);

        xfer(4'h0, 1'b0, 32'h0, '0);
        xfer(4'h0, 1'b1, 32'h0F, '0);
        xfer(4'h0, 1'b1, 32'h3C, '0);
        xfer(4'h0, 1'b1, 32'h3C, '0);
        xfer(4'h4, 1'b1, 32'hFFA5, '0);
        xfer(4'h4, 1'b0, 32'h0, 8'h5A);
        xfer(4'h8, 1'b0, 32'h0, 8'h5A);
        xfer(4'h8, 1'b1, 32'hFF, 8'h5A);
        xfer(4'hC, 1'b0, 32'h0, 8'h5A);
        xfer(4'h2, 1'b0, 32'h0, 8'h5A);
        xfer(4'h1, 1'b1, 32'hAA, 8'h5A);
        xfer(4'h0, 1'b0, 32'h0, 8'h5A);
        xfer(4'h4, 1'b0, 32'h0, 8'h5A);

        for (int n = 0; n < 60; n++) begin
            ra = {2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            rd = $urandom;
            xfer(ra, 1'($urandom), rd, NP'($urandom));
        end

        // Reset landing in the PULSE cycle of a DIR write.
        rd = 32'(~m_dir);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 4'h0; pwrite = 1'b1; pwdata = rd;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        chk("pulse_before_reset", 32'((w1 | r1) != '0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_w1", 32'(w1), 32'd0);
        chk("reset_r1", 32'(r1), 32'd0);
        chk("reset_dir", 32'(dir), 32'd0);
        chk("reset_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        m_dir = '0; m_out = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(4'h0, 1'b0, 32'h0, m_in);
        xfer(4'h4, 1'b0, 32'h0, m_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_dir_ctrl.md
# gpio_dir_ctrl

APB slave controller that owns the direction and output state of an NPINS-wide GPIO bank built from per-pin RS direction flops. It decodes bus transfers, keeps a shadow direction register, and sequences the single-cycle `w1`/`r1` set/clear pulses that move each pin flop between output (write) and input (read) mode. It also synchronises pad inputs for read-back. It sits between the APB interconnect and the GPIO pin array.

## Interface
- NPINS, 8, number of GPIO pins (1..32)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write transfer
- paddr  in  4  byte address; bits [3:2] select register
- pwdata  in  32  write data; bits above NPINS-1 ignored
- prdata  out  32  read data; valid only while pready=1, else 0
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid with pready
- gpio_in  in  NPINS  asynchronous pad inputs
- gpio_out  out  NPINS  output data register
- dir  out  NPINS  shadow direction, 1 = output, 0 = input
- w1  out  NPINS  one-cycle pulse: force pin flop to output mode
- r1  out  NPINS  one-cycle pulse: force pin flop to input mode

## Operation
- Register map (paddr[1:0] must be 0):
  - 0x0 DIR, R/W.
  - 0x4 OUT, R/W.
  - 0x8 IN, RO: 2-flop-synchronised gpio_in.
  - 0xC reserved.
- Read-back: upper bits (>= NPINS) read 0.
- States: IDLE, ACCESS, PULSE, RESP.
- IDLE:
  - psel=1, penable=0: latch paddr, pwrite, pwdata; go to ACCESS.
  - Otherwise stay.
- ACCESS (penable=1 expected):
  - Error case: bad address, paddr[1:0]≠0, or write to 0x8. Drive pready=1, pslverr=1, no state change; go to IDLE.
  - OUT write: gpio_out←pwdata at the end of this cycle. Drive pready=1; go to IDLE.
  - DIR read / OUT read: prdata driven, pready=1; go to IDLE.
  - DIR write or IN read: pready=0; go to PULSE.
- PULSE:
  - DIR write only: w1[i]=new[i]&~dir[i] and r1[i]=~new[i]&dir[i] for this one cycle. dir←new at the end of this cycle.
  - IN read: no pulses; prdata is captured from sync stage 2 at the end of this cycle.
  - pready=0; go to RESP.
- RESP:
  - pready=1, pslverr=0.
  - prdata = captured IN value (reads) or 0 (writes).
  - Go to IDLE.
- Invariants:
  - w1[i] and r1[i] are never both 1.
  - No pulse outside PULSE.
  - Rewriting an unchanged DIR value produces zero pulses but the same latency.
- Abort: psel=0 observed in ACCESS or PULSE returns the FSM to IDLE next cycle.
  - Abort in ACCESS: no register update, no pulses.
  - Abort in PULSE: the pulse and dir update still complete in that cycle.
- Back-to-back transfers: a new setup phase is accepted in the IDLE cycle that follows the RESP or ACCESS completion.

## Timing
- Reset (async assert, sync deassert by the system): FSM=IDLE; dir=0 (all input, matching the pin flops' reset state); gpio_out=0; w1=r1=0; prdata=0; pready=0; pslverr=0; synchronisers=0.
- No pulses are emitted as a result of reset release.
- Reset asserted mid-transfer aborts immediately. Outputs take reset values asynchronously and any in-flight pulse is truncated.
- Latency from setup cycle to pready=1:
  - OUT write, DIR/OUT read, error: 1 cycle, zero wait states.
  - DIR write, IN read: 3 cycles, two wait states.
- gpio_in to IN read-back: a value stable for 2 clocks before the PULSE cycle is returned.
- pready is high for exactly one cycle per transfer.
- pslverr is high only together with pready.

## Test plan
- Reset then DIR read at 0x0 -> pready in the access cycle, prdata=0x00, pslverr=0; w1=r1=0 throughout.
- DIR write 0x0F from reset -> w1=0x0F for exactly one cycle (the PULSE cycle), r1=0, dir=0x0F, pready after two wait states. Then DIR write 0x3C -> w1=0x30 and r1=0x03 in the same cycle, dir=0x3C.
- DIR write 0x3C twice -> second write has w1=r1=0 and the same 2-wait-state latency.
- OUT write 0xFFA5 with NPINS=8 -> gpio_out=0xA5 after the access cycle; OUT read returns 0x000000A5 with zero wait states.
- gpio_in=0x5A held 3 cycles, then IN read -> prdata=0x0000005A in RESP. Write to 0x8 and read of 0xC or 0x2 -> pslverr=1 with pready, no register change.
- Assert reset during the PULSE cycle of a DIR write -> w1/r1 drop to 0 asynchronously, dir=0, FSM IDLE; the next DIR read returns 0.
